seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/div_pkg.sv | 14 +
 rtl/div_ctrl.sv | 59 +++++
 rtl/seq_divider.sv | 98 +++++++++
 tb/tb_seq_divider.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared encodings and default sizes for the sequential restoring divider.
// Consumed by seq_divider (datapath, optional Div_zero under DIV_ZERO_FLAG_EN) and div_ctrl.
package div_pkg;

  localparam int DP_WIDTH_DEFAULT = 5;
  localparam int BC_SIZE_DEFAULT  = 3;

  typedef enum logic [2:0] {
    S_idle  = 3'b001,
    S_shift = 3'b010,
    S_sub   = 3'b100
  } state_t;

endpackage

// File: rtl/div_ctrl.sv
// Control FSM for the restoring divider: sequences load, alternating shift/subtract
// steps, and owns the registered Ready flag.
module div_ctrl
  import div_pkg::*;
(
  input  logic clock,
  input  logic reset_b,
  input  logic Start,
  input  logic Zero,
  input  logic Ovf_detect,
  output logic Load_regs,
  output logic Shift_regs,
  output logic Sub_regs,
  output logic Ready
);

  state_t state_q;
  logic   ready_q;

  // Ready is registered alongside the state so it is high exactly in S_idle.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= S_idle;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        S_idle: begin
          if (Start && !Ovf_detect) begin
            state_q <= S_shift;
            ready_q <= 1'b0;
          end
        end
        S_shift: begin
          state_q <= S_sub;
          ready_q <= 1'b0;
        end
        S_sub: begin
          if (Zero) begin
            state_q <= S_idle;
            ready_q <= 1'b1;
          end else begin
            state_q <= S_shift;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_idle;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign Load_regs  = (state_q == S_idle) && Start && !Ovf_detect;
  assign Shift_regs = (state_q == S_shift);
  assign Sub_regs   = (state_q == S_sub);
  assign Ready      = ready_q;

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: 2*dp_width-bit dividend by dp_width-bit divisor.
// Define DIV_ZERO_FLAG_EN to add the Div_zero output flag.
module seq_divider
  import div_pkg::*;
#(
  parameter int dp_width = DP_WIDTH_DEFAULT,
  parameter int BC_size  = BC_SIZE_DEFAULT
) (
  input  logic                    clock,
  input  logic                    reset_b,
  input  logic                    Start,
  input  logic [2*dp_width-1:0]   Dividend,
  input  logic [dp_width-1:0]     Divisor,
  output logic [dp_width-1:0]     Quotient,
  output logic [dp_width-1:0]     Remainder,
  output logic                    Ready,
`ifdef DIV_ZERO_FLAG_EN
  output logic                    Div_zero,
`endif
  output logic                    Overflow
);

  logic [dp_width-1:0] a_q, q_q, b_q;
  logic                e_q;
  logic [BC_size-1:0]  p_q;
  logic                overflow_q;

  logic                loadRegs, shiftRegs, subRegs;
  logic                ovfDetect, countZero, subOk;
  logic [dp_width-1:0] diffLow;

  // A quotient only fits when the upper dividend half is below the divisor.
  assign ovfDetect = (Dividend[2*dp_width-1:dp_width] >= Divisor);
  assign countZero = (p_q == '0);
  assign subOk     = ({e_q, a_q} >= {1'b0, b_q});
  assign diffLow   = a_q - b_q;

  div_ctrl u_ctrl (
    .clock      (clock),
    .reset_b    (reset_b),
    .Start      (Start),
    .Zero       (countZero),
    .Ovf_detect (ovfDetect),
    .Load_regs  (loadRegs),
    .Shift_regs (shiftRegs),
    .Sub_regs   (subRegs),
    .Ready      (Ready)
  );

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      a_q        <= '0;
      q_q        <= '0;
      b_q        <= '0;
      e_q        <= 1'b0;
      p_q        <= '0;
      overflow_q <= 1'b0;
    end else if (loadRegs) begin
      a_q        <= Dividend[2*dp_width-1:dp_width];
      q_q        <= Dividend[dp_width-1:0];
      b_q        <= Divisor;
      e_q        <= 1'b0;
      p_q        <= BC_size'(dp_width);
      overflow_q <= 1'b0;
    end else if (Ready && Start) begin
      overflow_q <= 1'b1;
    end else if (shiftRegs) begin
      {e_q, a_q, q_q} <= {a_q, q_q, 1'b0};
      p_q             <= p_q - BC_size'(1);
    end else if (subRegs) begin
      // Low bits of {E,A}-{0,B} equal A-B modulo 2**dp_width.
      if (subOk) begin
        a_q    <= diffLow;
        q_q[0] <= 1'b1;
      end
      e_q <= 1'b0;
    end
  end

`ifdef DIV_ZERO_FLAG_EN
  logic divZero_q;

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      divZero_q <= 1'b0;
    end else if (Ready && Start) begin
      divZero_q <= (Divisor == '0);
    end
  end

  assign Div_zero = divZero_q;
`endif

  assign Quotient  = q_q;
  assign Remainder = a_q;
  assign Overflow  = overflow_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider at the default 5-bit datapath; directed cases
// plus randomized divisions against an arithmetic reference (DIV_ZERO_FLAG_EN aware).
module tb_seq_divider;

  logic       clock = 1'b0;
  logic       reset_b = 1'b0;
  logic       Start = 1'b0;
  logic [9:0] Dividend = '0;
  logic [4:0] Divisor = '0;
  logic [4:0] Quotient, Remainder;
  logic       Ready, Overflow;
`ifdef DIV_ZERO_FLAG_EN
  logic       Div_zero;
`endif

  int checks = 0;
  int failures = 0;
  int expQ = 0, expR = 0;
  bit expOvf = 0, expDz = 0;

  seq_divider dut (
    .clock     (clock),
    .reset_b   (reset_b),
    .Start     (Start),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .Ready     (Ready),
`ifdef DIV_ZERO_FLAG_EN
    .Div_zero  (Div_zero),
`endif
    .Overflow  (Overflow)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic startOp(input int dvd, input int dvs);
    @(negedge clock);
    Dividend = 10'(dvd);
    Divisor  = 5'(dvs);
    Start    = 1'b1;
    @(negedge clock);
  endtask

  // Counts falling edges seen with Ready low; optionally injects a busy-time Start.
  task automatic waitReady(input int injectAt, input bit hold, output int cycles);
    cycles = 0;
    while (!Ready && cycles < 50) begin
      if (!hold) begin
        if (cycles == injectAt) begin
          Start    = 1'b1;
          Dividend = 10'd55;
          Divisor  = 5'd6;
        end else begin
          Start = 1'b0;
        end
      end
      cycles++;
      @(negedge clock);
    end
    if (!hold) Start = 1'b0;
  endtask

  task automatic checkResult(input string tag, input int dvd, input int dvs, input int cycles);
    if ((dvd / 32) >= dvs) begin
      expOvf = 1'b1;
      expDz  = (dvs == 0);
      checkOutput({tag, "_busy"}, cycles, 0);
    end else begin
      expQ   = dvd / dvs;
      expR   = dvd % dvs;
      expOvf = 1'b0;
      expDz  = 1'b0;
      checkOutput({tag, "_busy"}, cycles, 10);
    end
    checkOutput({tag, "_ready"}, int'(Ready), 1);
    checkOutput({tag, "_quot"}, int'(Quotient), expQ);
    checkOutput({tag, "_rem"}, int'(Remainder), expR);
    checkOutput({tag, "_ovf"}, int'(Overflow), int'(expOvf));
`ifdef DIV_ZERO_FLAG_EN
    checkOutput({tag, "_dz"}, int'(Div_zero), int'(expDz));
`endif
  endtask

  task automatic applyStimulus(input string tag, input int dvd, input int dvs);
    int c;
    startOp(dvd, dvs);
    waitReady(-1, 1'b0, c);
    checkResult(tag, dvd, dvs, c);
  endtask

  initial begin
    int c;
    repeat (2) @(negedge clock);
    checkOutput("rst_ready", int'(Ready), 1);
    checkOutput("rst_quot", int'(Quotient), 0);
    checkOutput("rst_rem", int'(Remainder), 0);
    checkOutput("rst_ovf", int'(Overflow), 0);
    reset_b = 1'b1;

    applyStimulus("d100_7", 100, 7);
    applyStimulus("d991_31", 991, 31);
    applyStimulus("d992_31", 992, 31);
    applyStimulus("d5_0", 5, 0);
    applyStimulus("d100_7b", 100, 7);

    startOp(100, 7);
    waitReady(3, 1'b0, c);
    checkResult("busyStart", 100, 7, c);

    startOp(100, 7);
    waitReady(-1, 1'b1, c);
    checkResult("heldStart", 100, 7, c);
    @(negedge clock);
    checkOutput("heldRestart", int'(Ready), 0);
    Start = 1'b0;
    waitReady(-1, 1'b0, c);
    checkOutput("heldDrain_quot", int'(Quotient), expQ);
    checkOutput("heldDrain_rem", int'(Remainder), expR);

    startOp(100, 7);
    Start = 1'b0;
    repeat (5) @(negedge clock);
    reset_b = 1'b0;
    #1;
    checkOutput("midRst_ready", int'(Ready), 1);
    checkOutput("midRst_quot", int'(Quotient), 0);
    checkOutput("midRst_rem", int'(Remainder), 0);
    checkOutput("midRst_ovf", int'(Overflow), 0);
    expQ = 0;
    expR = 0;
    expOvf = 1'b0;
    expDz = 1'b0;
    @(negedge clock);
    reset_b = 1'b1;
    applyStimulus("d0_5", 0, 5);

    for (int i = 0; i < 40; i++) begin
      int dvd, dvs;
      if (i % 2 == 0) begin
        dvs = int'($urandom_range(1, 31));
        dvd = dvs * int'($urandom_range(0, 31)) + int'($urandom_range(0, dvs - 1));
      end else begin
        dvd = int'($urandom_range(0, 1023));
        dvs = int'($urandom_range(0, 31));
      end
      applyStimulus($sformatf("rnd%0d_%0d_%0d", i, dvd, dvs), dvd, dvs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
